// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI-to-RAM loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RISSUE,
        RCAP,
        RSHIFT,
        DONE
    } state_t;

    // Write/read selector inside the command byte
    localparam int CMD_W_BIT = 7;

    // Bit positions inside the RAM control byte
    localparam int LR_N_BIT = 7;
    localparam int CE_N_BIT = 6;

    // Pack strobes and address into the RAM control byte layout
    function automatic logic [7:0] ram_ctrl(input logic       lr_n,
                                            input logic       ce_n,
                                            input logic [5:0] addr);
        logic [7:0] c;
        c           = {2'b00, addr};
        c[LR_N_BIT] = lr_n;
        c[CE_N_BIT] = ce_n;
        return c;
    endfunction

endpackage

// File: rtl/spi_mem_loader_if.sv
// RAM-side bus between the SPI loader (master) and the DFF RAM (slave).
// Latency: wires only; mem_ctrl is the packed control byte seen by the RAM.
// Backpressure: none; the RAM accepts one strobe per cycle.
interface spi_mem_loader_if #(
    parameter int ADDR_BITS = 4
);
    import spi_mem_pkg::*;

    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_lr_n;
    logic                 mem_ce_n;
    logic [7:0]           mem_wdata;
    logic [7:0]           mem_rdata;
    logic [7:0]           mem_ctrl;

    // RAM control byte: {lr_n, ce_n, zero-extended address}
    assign mem_ctrl = ram_ctrl(mem_lr_n, mem_ce_n, 6'(mem_addr));

    modport master (
        output mem_addr, mem_lr_n, mem_ce_n, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_lr_n, mem_ce_n, mem_wdata, mem_ctrl,
        output mem_rdata
    );

endinterface

// File: rtl/spi_sync.sv
// N-flop synchroniser with rise/fall pulses taken from the last two synchronised samples.
// Latency: N clk cycles to q; edge pulses one cycle wide, in the cycle q first shows the new level.
// Backpressure: none.
module spi_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [N-1:0] chain;
    logic         q_d;

    // Shift the asynchronous input through the chain and keep the previous synchronised sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {N{RST_VAL}};
            q_d   <= RST_VAL;
        end else begin
            chain <= {chain[N-2:0], d};
            q_d   <= chain[N-1];
        end
    end

    assign q    = chain[N-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/spi_mem_loader.sv
// SPI mode-0 slave turning command/data bytes into RAM write strobes and reads; SPI_MEM_BURST_EN enables auto-increment bursts.
// Latency: write strobe the cycle after the 8th synchronised rise; first MISO bit 3 clk after the command's 8th rise.
// Backpressure: none; host must keep sclk period >= 8 clk so every edge is seen and reads complete in time.
module spi_mem_loader
    import spi_mem_pkg::*;
#(
    parameter int RAM_BYTES   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    spi_mem_loader_if.master  mem,
    output logic              busy,
    output logic              frame_err
);

    // Address width must not exceed the 6 address bits of the RAM control byte
    localparam int                   ADDR_BITS = $clog2(RAM_BYTES);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(RAM_BYTES - 1);

    logic sclk_q, sclk_rise, sclk_fall;
    logic cs_q, cs_rise, cs_fall;
    logic mosi_q, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(spi_sclk),
        .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d(spi_cs_n),
        .q(cs_q), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(spi_mosi),
        .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Only the sclk edge pulses and the mosi level matter here
    assign unused_sync = ^{sclk_q, mosi_rise, mosi_fall};

    assign busy = ~cs_q;

    logic [2:0] bit_cnt;
    logic [7:0] shift_in;
    logic [7:0] shift_out;
    logic       byte_done;
    logic [7:0] rx_byte;
    state_t     state;

    assign byte_done = sclk_rise & ~cs_q & (bit_cnt == 3'd7);
    assign rx_byte   = {shift_in[6:0], mosi_q};

    function automatic logic [ADDR_BITS-1:0] addr_inc(input logic [ADDR_BITS-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    // Count sampled rises and assemble MSB-first bytes; deselect clears the partial byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= 3'd0;
            shift_in <= 8'h00;
        end else if (cs_q) begin
            bit_cnt  <= 3'd0;
        end else if (sclk_rise) begin
            bit_cnt  <= bit_cnt + 3'd1;
            shift_in <= rx_byte;
        end
    end

    // Frame FSM: command decode, write strobes, read issue/capture and MISO shifting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mem.mem_addr  <= '0;
            mem.mem_lr_n  <= 1'b1;
            mem.mem_ce_n  <= 1'b1;
            mem.mem_wdata <= 8'h00;
            spi_miso      <= 1'b0;
            shift_out     <= 8'h00;
            frame_err     <= 1'b0;
        end else begin
            // A deselect with bits pending means the host abandoned a byte
            frame_err <= cs_rise && (bit_cnt != 3'd0);

            if (cs_rise) begin
                state        <= IDLE;
                mem.mem_lr_n <= 1'b1;
                mem.mem_ce_n <= 1'b1;
                spi_miso     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) state <= CMD;
                    end
                    CMD: begin
                        if (byte_done) begin
                            mem.mem_addr <= rx_byte[ADDR_BITS-1:0];
                            if (rx_byte[CMD_W_BIT]) begin
                                state <= WDATA;
                            end else begin
                                state        <= RISSUE;
                                mem.mem_ce_n <= 1'b0;
                            end
                        end
                    end
                    WDATA: begin
                        // Strobe lasts one cycle; the address moves on only after it
                        if (!mem.mem_lr_n) begin
                            mem.mem_lr_n <= 1'b1;
`ifdef SPI_MEM_BURST_EN
                            mem.mem_addr <= addr_inc(mem.mem_addr);
`endif
                        end
                        if (byte_done) begin
                            mem.mem_wdata <= rx_byte;
                            mem.mem_lr_n  <= 1'b0;
`ifndef SPI_MEM_BURST_EN
                            state         <= DONE;
`endif
                        end
                    end
                    RISSUE: begin
                        state <= RCAP;
                    end
                    RCAP: begin
                        mem.mem_ce_n <= 1'b1;
                        shift_out    <= mem.mem_rdata;
                        spi_miso     <= mem.mem_rdata[7];
                        state        <= RSHIFT;
                    end
                    RSHIFT: begin
                        if (byte_done) begin
                            spi_miso <= 1'b0;
`ifdef SPI_MEM_BURST_EN
                            mem.mem_addr <= addr_inc(mem.mem_addr);
                            mem.mem_ce_n <= 1'b0;
                            state        <= RISSUE;
`else
                            state        <= DONE;
`endif
                        end else if (sclk_fall && (bit_cnt != 3'd0)) begin
                            // The fall after a byte's last rise is skipped: MSB already presented
                            shift_out <= {shift_out[6:0], 1'b0};
                            spi_miso  <= shift_out[6];
                        end
                    end
                    DONE: begin
                        mem.mem_lr_n <= 1'b1;
                        mem.mem_ce_n <= 1'b1;
                        spi_miso     <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_loader.sv
// Directed bench for spi_mem_loader with a registered 16-byte RAM model on the interface.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_mem_loader;
    import spi_mem_pkg::*;

    logic clk      = 1'b0;
    logic rst_n    = 1'b1;
    logic spi_sclk = 1'b0;
    logic spi_cs_n = 1'b1;
    logic spi_mosi = 1'b0;
    logic spi_miso;
    logic busy;
    logic frame_err;

    int vec_cnt    = 0;
    int miscompares = 0;

    spi_mem_loader_if #(.ADDR_BITS(4)) mem_if ();

    spi_mem_loader #(.RAM_BYTES(16), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_sclk  (spi_sclk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .mem       (mem_if),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // RAM model: decodes the packed control byte, registered read data
    logic [7:0] ram [16];
    logic       bd_we   = 1'b0;
    logic [3:0] bd_addr = 4'd0;
    logic [7:0] bd_data = 8'h00;

    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        if (!mem_if.mem_ctrl[LR_N_BIT]) ram[mem_if.mem_ctrl[3:0]] <= mem_if.mem_wdata;
        if (!mem_if.mem_ctrl[CE_N_BIT]) mem_if.mem_rdata <= ram[mem_if.mem_ctrl[3:0]];
    end

    // Bus monitor sampled mid-cycle
    int         wr_cnt   = 0;
    int         ce_cnt   = 0;
    int         ferr_cnt = 0;
    logic [3:0] wr_addr  = 4'd0;
    logic [7:0] wr_data  = 8'h00;
    logic       both_low = 1'b0;
    logic [3:0] ce_addr_q [$];

    always @(negedge clk) begin
        if (rst_n && !mem_if.mem_lr_n) begin
            wr_cnt  = wr_cnt + 1;
            wr_addr = mem_if.mem_addr;
            wr_data = mem_if.mem_wdata;
        end
        if (rst_n && !mem_if.mem_ce_n) begin
            ce_cnt = ce_cnt + 1;
            ce_addr_q.push_back(mem_if.mem_addr);
        end
        if (!mem_if.mem_lr_n && !mem_if.mem_ce_n) both_low = 1'b1;
        if (frame_err) ferr_cnt = ferr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt = vec_cnt + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    // sclk half period 40 ns = 4 clk; all edges land on clk falling edges
    task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            #40 spi_sclk = 1'b1;
            rx[i] = spi_miso;
            #40 spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_bits(input int n, input logic [7:0] tx);
        for (int i = 0; i < n; i++) begin
            spi_mosi = tx[7-i];
            #40 spi_sclk = 1'b1;
            #40 spi_sclk = 1'b0;
        end
    endtask

    task automatic frame_begin();
        @(negedge clk);
        spi_cs_n = 1'b0;
        #100;
    endtask

    task automatic frame_end();
        #100 spi_cs_n = 1'b1;
        #200;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_lr_n"},  mem_if.mem_lr_n,  1);
        chk({tag, "_ce_n"},  mem_if.mem_ce_n,  1);
        chk({tag, "_addr"},  mem_if.mem_addr,  0);
        chk({tag, "_wdata"}, mem_if.mem_wdata, 0);
        chk({tag, "_miso"},  spi_miso,         0);
        chk({tag, "_busy"},  busy,             0);
        chk({tag, "_ferr"},  frame_err,        0);
    endtask

    logic [7:0] rx;
    int         w0, c0, f0, q0;

    initial begin
        // Power-on reset
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        poke(4'd1, 8'h77);
        poke(4'd5, 8'h3C);
        poke(4'd7, 8'hFF);

        // Single write 0x83, 0xA5
        w0 = wr_cnt; c0 = ce_cnt; f0 = ferr_cnt;
        frame_begin();
        chk("busy_in_frame", busy, 1);
        spi_xfer(8'h83, rx);
        spi_xfer(8'hA5, rx);
        frame_end();
        chk("wr1_count", wr_cnt - w0, 1);
        chk("wr1_addr",  wr_addr, 4'd3);
        chk("wr1_data",  wr_data, 8'hA5);
        chk("wr1_ram3",  ram[3],  8'hA5);
        chk("wr1_no_ce", ce_cnt - c0, 0);
        chk("wr1_no_ferr", ferr_cnt - f0, 0);
        chk("busy_idle", busy, 0);

        // Single read of address 5
        c0 = ce_cnt; q0 = ce_addr_q.size();
        frame_begin();
        spi_xfer(8'h05, rx);
        spi_xfer(8'h00, rx);
        chk("rd1_data", rx, 8'h3C);
        frame_end();
`ifdef SPI_MEM_BURST_EN
        chk("rd1_ce_cycles", ce_cnt - c0, 4);
`else
        chk("rd1_ce_cycles", ce_cnt - c0, 2);
`endif
        chk("rd1_ce_addr0", ce_addr_q[q0],   4'd5);
        chk("rd1_ce_addr1", ce_addr_q[q0+1], 4'd5);
        chk("rd1_miso_idle", spi_miso, 0);

`ifdef SPI_MEM_BURST_EN
        // Burst write across the top of the address space
        w0 = wr_cnt;
        frame_begin();
        spi_xfer(8'h8E, rx);
        spi_xfer(8'h11, rx);
        spi_xfer(8'h22, rx);
        spi_xfer(8'h33, rx);
        frame_end();
        chk("bw_count", wr_cnt - w0, 3);
        chk("bw_ram14", ram[14], 8'h11);
        chk("bw_ram15", ram[15], 8'h22);
        chk("bw_ram0",  ram[0],  8'h33);

        // Burst read of the same three bytes
        frame_begin();
        spi_xfer(8'h0E, rx);
        spi_xfer(8'h00, rx);
        chk("br_byte0", rx, 8'h11);
        spi_xfer(8'h00, rx);
        chk("br_byte1", rx, 8'h22);
        spi_xfer(8'h00, rx);
        chk("br_byte2", rx, 8'h33);
        frame_end();
`else
        // One data byte per frame: the second write byte is dropped
        w0 = wr_cnt;
        frame_begin();
        spi_xfer(8'h80, rx);
        spi_xfer(8'h01, rx);
        spi_xfer(8'h02, rx);
        frame_end();
        chk("nb_wr_count", wr_cnt - w0, 1);
        chk("nb_ram0", ram[0], 8'h01);
        chk("nb_ram1", ram[1], 8'h77);

        // One read byte per frame: the second byte reads back as zero
        c0 = ce_cnt;
        frame_begin();
        spi_xfer(8'h03, rx);
        spi_xfer(8'h00, rx);
        chk("nb_rd_byte0", rx, 8'hA5);
        spi_xfer(8'hFF, rx);
        chk("nb_rd_byte1", rx, 8'h00);
        frame_end();
        chk("nb_rd_ce_cycles", ce_cnt - c0, 2);
`endif

        // Abort after 4 bits of a data byte
        w0 = wr_cnt; f0 = ferr_cnt;
        frame_begin();
        spi_xfer(8'h83, rx);
        spi_bits(4, 8'hF0);
        frame_end();
        chk("abort_no_write", wr_cnt - w0, 0);
        chk("abort_ferr_once", ferr_cnt - f0, 1);
        chk("abort_busy", busy, 0);

        // A clean frame after the abort still writes
        w0 = wr_cnt; f0 = ferr_cnt;
        frame_begin();
        spi_xfer(8'h82, rx);
        spi_xfer(8'h5A, rx);
        frame_end();
        chk("post_abort_count", wr_cnt - w0, 1);
        chk("post_abort_ram2", ram[2], 8'h5A);
        chk("post_abort_no_ferr", ferr_cnt - f0, 0);

        // Asynchronous reset in the middle of a read of address 7
        frame_begin();
        spi_xfer(8'h07, rx);
        #100;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_addr", mem_if.mem_addr, 4'd7);
        chk("pre_rst_miso", spi_miso, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        chk("never_both_strobes", both_low, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
